seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Parametrised multiplexed 7-segment display driver, the next generation of the board's 4-digit hex display path. It accepts a DIGITS-wide packed hex value through a load strobe and double-buffers it so the display only changes on a frame boundary (no tearing). Each digit is decoded internally, and digits are scanned with a built-in refresh prescaler and PWM brightness control. It sits between any value source (ROM sequencer, counter) and the DS_* pins in the top level, replacing the separate per-digit decoder and scanner instances.

## Interface
- DIGITS, 4: number of digits scanned; ≥1.
- DIV_W, 10: prescaler width; each digit slot lasts 2^DIV_W cycles.
- BRIGHT_W, 3: brightness control width; BRIGHT_W ≤ DIV_W.
- SEG_INV, 0: 1 = segments active-low at the pins.
- EN_INV, 0: 1 = digit enables active-low at the pins.

Ports:
- CLK  in  1  sole clock.
- RST_N  in  1  synchronous, active-low reset.
- VALUE  in  4*DIGITS  packed hex; nibble 0 → digit 0 (least significant).
- LOAD  in  1  one-cycle strobe; captures VALUE.
- BRIGHT  in  BRIGHT_W  on-time in 1/2^BRIGHT_W steps; 0 = dark.
- PENDING  out  1  loaded value not yet displayed.
- FRAME  out  1  one-cycle pulse at each frame start.
- SEG  out  7  segments {a,b,c,d,e,f,g}, a = MSB.
- SEGEN  out  DIGITS  one-hot digit enable; bit i → digit i.
- DIGIT_IDX  out  max(1,$clog2(DIGITS))  digit currently driven.

## Operation
- Registers:
  - prescaler `pre` (DIV_W bits).
  - digit index `idx` (0..DIGITS-1).
  - `pend_val` and `PENDING`.
  - `shadow` (the displayed value).
- Wrap cycle: the cycle in which `pre` is all-ones. On that edge:
  - `pre` returns to 0.
  - `idx` advances, wrapping from DIGITS-1 to 0.
- Frame edge: a wrap cycle with `idx`==DIGITS-1.
- Load rules:
  - LOAD outside a frame edge: `pend_val` ← VALUE and PENDING ← 1. A repeat LOAD overwrites `pend_val` (last wins).
  - Frame edge with PENDING=1 and no LOAD: `shadow` ← `pend_val` and PENDING ← 0.
  - Frame edge with LOAD: bypass, `shadow` ← VALUE and PENDING ← 0. Any older pending value is discarded.
- Digit lit condition: digit `idx` is lit while `pre`[DIV_W-1 -: BRIGHT_W] < BRIGHT. Otherwise SEGEN is all inactive and SEG is blank.
- SEG = decode of `shadow` nibble `idx`, using the standard hex font 0–F.
- Blank means all segments off, in output polarity.
- Polarity: SEG is XORed with {7{SEG_INV}}; SEGEN is XORed with {DIGITS{EN_INV}}.

## Timing
- Outputs are registered. SEG, SEGEN and DIGIT_IDX reflect the `pre`/`idx`/`shadow` state of the previous cycle (1-cycle latency).
- FRAME is high in the cycle after the frame edge, aligned with the first output cycle of digit 0.
- Timing figures:
  - Frame period: DIGITS·2^DIV_W cycles.
  - Lit cycles per slot: BRIGHT·2^(DIV_W-BRIGHT_W).
  - Latency from LOAD to first display: at most one frame period + 1 cycle.
- Reset (RST_N low at an edge) applies at any point, including mid-frame, and takes effect on the next edge:
  - `pre`=0, `idx`=0, `shadow`=0, `pend_val`=0, PENDING=0.
  - FRAME=0, DIGIT_IDX=0, SEG=blank, SEGEN=all inactive.
  - LOAD during reset is ignored.
- Scanning restarts from digit 0 on the first cycle after RST_N rises. No FRAME pulse is produced for that first frame.
- DIGITS=1: every wrap cycle is a frame edge.

## Configuration
- SEG_SCAN_LZB_EN:
  - Defined: leading-zero blanking. Digit i is blanked (SEG blank, SEGEN inactive for the whole slot) when all `shadow` nibbles i..DIGITS-1 are 0 and i>0. Digit 0 is never blanked, so 0 shows as a single "0".
  - Undefined: all digits are always shown, including leading zeros.

## Structure
- Package seg_pkg holds:
  - The 16 font constants (active-high, a = MSB).
  - SEG_BLANK.
  - A helper computing the DIGIT_IDX width.
- One sub-module, seg_decode: combinational 4-bit → 7-segment decoder using the seg_pkg constants. It is instantiated once, on the muxed nibble.
- Prescaler, index, buffer and PWM logic stay in seg_scan_driver.

## Test plan
Bench parameters: DIGITS=4, DIV_W=4, BRIGHT_W=2, SEG_INV=EN_INV=0; frame = 64 cycles.
- Reset: hold RST_N=0 for 3 cycles → SEG=7'b0000000, SEGEN=4'b0000, PENDING=0. After release with BRIGHT=3, digit 0 shows 7'b1111110.
- Scan and PWM: LOAD 16'h1A2F, BRIGHT=3 → after the next FRAME the digits show:
  - digit 0: 7'b1000111.
  - digit 1: 7'b1101101.
  - digit 2: 7'b1110111.
  - digit 3: 7'b0110000.
  - Each SEGEN bit is high for 12 of its 16 slot cycles.
- Double buffer: LOAD 16'h1111 at frame cycle 10, then 16'h2222 at cycle 20 → display unchanged until FRAME. PENDING is high from cycle 11 up to the frame edge. The next frame shows 2222.
- Bypass: LOAD 16'h0005 exactly in the frame-edge cycle → digit 0 of the starting frame shows 5, and PENDING never rises.
- LZB (with SEG_SCAN_LZB_EN): VALUE 16'h0070 → SEGEN[3] and SEGEN[2] stay 0 all frame; digits 1 and 0 show 7 and 0. Without the macro → all four digits are lit.
- Dark and mid-frame reset: BRIGHT=0 → SEGEN stays 0 for a full frame. Then BRIGHT=2 with RST_N pulsed low at frame cycle 37 → next cycle SEGEN=0 and DIGIT_IDX=0; the display resumes at digit 0 showing "0".

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: hex font table and sizing helper shared by the
// scanned 7-segment display path.
package seg_pkg;

   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1111011;
   localparam logic [6:0] SEG_A = 7'b1110111;
   localparam logic [6:0] SEG_B = 7'b0011111;
   localparam logic [6:0] SEG_C = 7'b1001110;
   localparam logic [6:0] SEG_D = 7'b0111101;
   localparam logic [6:0] SEG_E = 7'b1001111;
   localparam logic [6:0] SEG_F = 7'b1000111;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic int idx_w(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational hex nibble to 7-segment pattern,
// active-high, segment a in the MSB.
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      unique case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered, PWM-dimmed multiplexed hex display.
// Define SEG_SCAN_LZB_EN to blank leading zero digits.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int DIV_W    = 10,
   parameter int BRIGHT_W = 3,
   parameter bit SEG_INV  = 1'b0,
   parameter bit EN_INV   = 1'b0
)(
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [4*DIGITS-1:0]       VALUE,
   input  logic                      LOAD,
   input  logic [BRIGHT_W-1:0]       BRIGHT,
   output logic                      PENDING,
   output logic                      FRAME,
   output logic [6:0]                SEG,
   output logic [DIGITS-1:0]         SEGEN,
   output logic [idx_w(DIGITS)-1:0]  DIGIT_IDX
);

   localparam int IW = idx_w(DIGITS);
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
   localparam logic [6:0] SEG_OFF = SEG_BLANK ^ {7{SEG_INV}};
   localparam logic [DIGITS-1:0] EN_OFF = {DIGITS{EN_INV}};

   logic [DIV_W-1:0]    pre;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] shadow;
   logic [4*DIGITS-1:0] pend_val;
   logic                fe_d;

   logic                wrap;
   logic                frame_edge;
   logic                lit;
   logic [3:0]          nib;
   logic [6:0]          dec;
   logic [DIGITS-1:0]   onehot;
   logic [DIGITS-1:0]   lzb;

   assign wrap       = &pre;
   assign frame_edge = wrap && (idx == LAST);
   assign nib        = shadow[{idx, 2'b00} +: 4];
   assign onehot     = DIGITS'(1) << idx;

   always_comb begin
      lzb = '0;
`ifdef SEG_SCAN_LZB_EN
      for (int i = DIGITS - 1; i > 0; i--)
         lzb[i] = ((shadow >> (4 * i)) == '0);
`endif
   end

   // PWM compares the top prescaler bits against the brightness code
   assign lit = (pre[DIV_W-1 -: BRIGHT_W] < BRIGHT) && !lzb[idx];

   seg_decode u_dec (
      .nibble (nib),
      .seg    (dec)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         pre       <= '0;
         idx       <= '0;
         shadow    <= '0;
         pend_val  <= '0;
         PENDING   <= 1'b0;
         fe_d      <= 1'b0;
         FRAME     <= 1'b0;
         DIGIT_IDX <= '0;
         SEG       <= SEG_OFF;
         SEGEN     <= EN_OFF;
      end else begin
         pre <= pre + 1'b1;
         if (wrap)
            idx <= (idx == LAST) ? '0 : idx + 1'b1;

         // a load landing on the frame edge goes straight to the display
         if (frame_edge) begin
            if (LOAD)
               shadow <= VALUE;
            else if (PENDING)
               shadow <= pend_val;
            PENDING <= 1'b0;
         end else if (LOAD) begin
            pend_val <= VALUE;
            PENDING  <= 1'b1;
         end

         fe_d      <= frame_edge;
         FRAME     <= fe_d;
         DIGIT_IDX <= idx;
         SEG       <= lit ? (dec ^ {7{SEG_INV}}) : SEG_OFF;
         SEGEN     <= lit ? (onehot ^ EN_OFF) : EN_OFF;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: 4 digits, 16-cycle slots, 64-cycle frame.
// Expected frames are queued at load time and popped per output cycle.
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] value;
   logic        load;
   logic [1:0]  bright;
   logic        pending;
   logic        frame;
   logic [6:0]  seg;
   logic [3:0]  segen;
   logic [1:0]  digit_idx;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0] segen;
      logic [6:0] seg;
      logic [1:0] idx;
      logic       frame;
   } obs_t;

   typedef struct {
      logic [15:0]     val;
      logic [1:0]      br;
      logic [3:0][6:0] seg;
      int              on;
   } vec_t;

   obs_t       sbq[$];
   int         lit_cnt[4];
   logic [6:0] seen_seg[4];

   seg_scan_driver #(
      .DIGITS   (4),
      .DIV_W    (4),
      .BRIGHT_W (2),
      .SEG_INV  (1'b0),
      .EN_INV   (1'b0)
   ) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .VALUE     (value),
      .LOAD      (load),
      .BRIGHT    (bright),
      .PENDING   (pending),
      .FRAME     (frame),
      .SEG       (seg),
      .SEGEN     (segen),
      .DIGIT_IDX (digit_idx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [6:0] font(input logic [3:0] n);
      logic [6:0] f;
      f = 7'b0;
      case (n)
         4'h0: f = 7'b1111110;
         4'h1: f = 7'b0110000;
         4'h2: f = 7'b1101101;
         4'h3: f = 7'b1111001;
         4'h4: f = 7'b0110011;
         4'h5: f = 7'b1011011;
         4'h6: f = 7'b1011111;
         4'h7: f = 7'b1110000;
         4'h8: f = 7'b1111111;
         4'h9: f = 7'b1111011;
         4'hA: f = 7'b1110111;
         4'hB: f = 7'b0011111;
         4'hC: f = 7'b1001110;
         4'hD: f = 7'b0111101;
         4'hE: f = 7'b1001111;
         4'hF: f = 7'b1000111;
         default: f = 7'b0;
      endcase
      return f;
   endfunction

   // expected pins for output cycle j (0..63) of a frame
   function automatic obs_t exp_at(input logic [15:0] v,
                                   input logic [1:0] br,
                                   input int j);
      obs_t o;
      int   d;
      int   p;
      logic on;
      d  = j / 16;
      p  = j % 16;
      on = (p / 4) < int'(br);
`ifdef SEG_SCAN_LZB_EN
      if (d > 0 && (v >> (4 * d)) == 16'h0)
         on = 1'b0;
`endif
      o.idx   = 2'(d);
      o.frame = (j == 0);
      o.seg   = on ? font(4'(v >> (4 * d))) : 7'b0;
      o.segen = on ? 4'(1 << d) : 4'b0;
      return o;
   endfunction

   task automatic push_frame(input logic [15:0] v, input logic [1:0] br);
      for (int j = 0; j < 64; j++)
         sbq.push_back(exp_at(v, br, j));
   endtask

   task automatic wait_frame(input string nm);
      int n = 0;
      while (frame !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check({nm, " frame"}, 32'(frame), 32'd1);
   endtask

   task automatic check_frame(input string nm);
      obs_t e;
      for (int d = 0; d < 4; d++) begin
         lit_cnt[d]  = 0;
         seen_seg[d] = 7'b0;
      end
      wait_frame(nm);
      for (int j = 0; j < 64; j++) begin
         e = sbq.pop_front();
         check($sformatf("%s out c%0d", nm, j),
               32'({segen, seg, digit_idx, frame}), 32'(e));
         check($sformatf("%s pend c%0d", nm, j), 32'(pending), 32'd0);
         for (int d = 0; d < 4; d++)
            if (segen[d]) begin
               lit_cnt[d]++;
               seen_seg[d] = seg;
            end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t       vt[4];
      logic [15:0] old_val;
      int          nfr;
      obs_t        o;
      int          lzb_on;

      vt[0] = '{16'h1A2F, 2'd3,
                {7'b0110000, 7'b1110111, 7'b1101101, 7'b1000111}, 12};
      vt[1] = '{16'h3D60, 2'd2,
                {7'b1111001, 7'b0111101, 7'b1011111, 7'b1111110}, 8};
      vt[2] = '{16'h9E47, 2'd1,
                {7'b1111011, 7'b1001111, 7'b0110011, 7'b1110000}, 4};
      vt[3] = '{16'hB8C0, 2'd3,
                {7'b0011111, 7'b1111111, 7'b1001110, 7'b1111110}, 12};

      // reset, with a load that must be ignored
      rst_n  = 1'b0;
      load   = 1'b1;
      value  = 16'hFFFF;
      bright = 2'd3;
      repeat (3) tick();
      check("rst seg", 32'(seg), 32'h00);
      check("rst segen", 32'(segen), 32'h0);
      check("rst pending", 32'(pending), 32'd0);
      check("rst frame", 32'(frame), 32'd0);
      check("rst idx", 32'(digit_idx), 32'd0);
      rst_n = 1'b1;
      load  = 1'b0;
      tick();
      check("rel seg", 32'(seg), 32'h7E);
      check("rel segen", 32'(segen), 32'h1);
      check("rel pending", 32'(pending), 32'd0);
      nfr = 0;
      for (int k = 1; k < 64; k++) begin
         tick();
         if (frame) nfr++;
      end
      check("no first frame", 32'(nfr), 32'd0);
      tick();
      check("second frame", 32'(frame), 32'd1);

      // vector table: load mid-frame, check the following frame
      for (int k = 0; k < 4; k++) begin
         bright = vt[k].br;
         value  = vt[k].val;
         load   = 1'b1;
         push_frame(vt[k].val, vt[k].br);
         tick();
         load = 1'b0;
         check_frame($sformatf("vec%0d", k));
         for (int d = 0; d < 4; d++) begin
            check($sformatf("vec%0d lit d%0d", k, d),
                  32'(lit_cnt[d]), 32'(vt[k].on));
            check($sformatf("vec%0d seg d%0d", k, d),
                  32'(seen_seg[d]), 32'(vt[k].seg[d]));
         end
      end

      // double buffer: loads at cycles 10 and 20, last wins at frame
      old_val = 16'hB8C0;
      repeat (9) tick();
      value = 16'h1111;
      load  = 1'b1;
      tick();
      load = 1'b0;
      for (int c = 11; c < 64; c++) begin
         if (c == 20) begin
            value = 16'h2222;
            load  = 1'b1;
            push_frame(16'h2222, 2'd3);
         end
         o = exp_at(old_val, 2'd3, c - 1);
         check($sformatf("db pend c%0d", c), 32'(pending), 32'd1);
         check($sformatf("db hold c%0d", c),
               32'({segen, seg, digit_idx, frame}), 32'(o));
         tick();
         load = 1'b0;
      end
      check("db pend clear", 32'(pending), 32'd0);
      tick();
      check_frame("dbuf");
      check("dbuf d3", 32'(seen_seg[3]), 32'h6D);

      // bypass: load exactly in the frame-edge cycle
      repeat (62) begin
         tick();
         check("byp pend pre", 32'(pending), 32'd0);
      end
      value = 16'h0005;
      load  = 1'b1;
      push_frame(16'h0005, 2'd3);
      tick();
      load = 1'b0;
      check("byp pend edge", 32'(pending), 32'd0);
      tick();
      check_frame("bypass");
      check("byp d0", 32'(seen_seg[0]), 32'h5B);

      // leading-zero blanking
      value = 16'h0070;
      load  = 1'b1;
      push_frame(16'h0070, 2'd3);
      tick();
      load = 1'b0;
      check_frame("lzb");
`ifdef SEG_SCAN_LZB_EN
      lzb_on = 0;
`else
      lzb_on = 12;
`endif
      check("lzb d3 lit", 32'(lit_cnt[3]), 32'(lzb_on));
      check("lzb d2 lit", 32'(lit_cnt[2]), 32'(lzb_on));
      check("lzb d1 seg", 32'(seen_seg[1]), 32'h70);
      check("lzb d0 seg", 32'(seen_seg[0]), 32'h7E);

      // dark
      bright = 2'd0;
      value  = 16'h8888;
      load   = 1'b1;
      push_frame(16'h8888, 2'd0);
      tick();
      load = 1'b0;
      check_frame("dark");

      // mid-frame reset at cycle 37
      bright = 2'd2;
      repeat (36) tick();
      rst_n = 1'b0;
      tick();
      check("mrst segen", 32'(segen), 32'h0);
      check("mrst idx", 32'(digit_idx), 32'd0);
      check("mrst seg", 32'(seg), 32'h00);
      check("mrst frame", 32'(frame), 32'd0);
      rst_n = 1'b1;
      tick();
      check("mrst d0 seg", 32'(seg), 32'h7E);
      check("mrst d0 en", 32'(segen), 32'h1);
      check("mrst d0 idx", 32'(digit_idx), 32'd0);
      push_frame(16'h0000, 2'd2);
      check_frame("post rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
